// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the FP ALU units.
// Field widths, working-register geometry, sequencer states and a field struct.
package fp_pkg;
    localparam int EXP_W       = 8;
    localparam int MAN_W       = 23;
    localparam int EXP_BIAS    = 127;
    localparam int EXP_SPECIAL = 255;
    localparam int WORK_W      = 27;
    localparam int SIG_W       = MAN_W + 1;
    localparam int XEXP_W      = 10;

    typedef enum logic [2:0] {
        IDLE, UNPACK, SPECIAL, ALIGN, ADDSUB, NORM, PACK, DONE
    } fp_state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_fields;

    function automatic logic [31:0] fp_inf(input logic sign);
        return {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    endfunction
endpackage

// File: rtl/fp_unpack.sv
// Splits a single-precision word into fields and forms the 24-bit significand.
// Exponent 0 is flushed to zero, so denormals never reach the datapath.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]      word,
    output fp_fields         fields,
    output logic             is_zero,
    output logic             is_special,
    output logic [SIG_W-1:0] sig
);
    always_comb begin
        fields     = fp_fields'(word);
        is_zero    = (fields.exp == '0);
        is_special = (fields.exp == EXP_W'(EXP_SPECIAL));
        sig        = is_zero ? '0 : {1'b1, fields.man};
    end
endmodule

// File: rtl/fp_sub_seq.sv
// Sequential single-precision subtractor: out = para1 - para2, aligning and
// normalising one bit per cycle behind a start/busy/done handshake.
module fp_sub_seq
    import fp_pkg::*;
#(
    parameter int MAX_ALIGN = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] para1,
    input  logic [31:0] para2,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic        under_overflow
);
    localparam logic signed [XEXP_W-1:0] EXP_ONE   = XEXP_W'(1);
    localparam logic signed [XEXP_W-1:0] EXP_MAX   = XEXP_W'(EXP_SPECIAL);
    localparam logic signed [XEXP_W-1:0] ALIGN_LIM = XEXP_W'(MAX_ALIGN);
    localparam logic [EXP_W-1:0]         DIFF_ONE  = EXP_W'(1);

    fp_state_t                 state_q, state_d;
    logic                      busy_q, busy_d, done_q, done_d, uf_q, uf_d;
    logic                      res_uf_q, res_uf_d, sign_q, sign_d, sub_q, sub_d;
    logic [31:0]               out_q, out_d, a_q, a_d, b_q, b_d, res_q, res_d;
    logic signed [XEXP_W-1:0]  exp_q, exp_d;
    logic [EXP_W-1:0]          diff_q, diff_d;
    logic [WORK_W-1:0]         ma_q, ma_d, mb_q, mb_d;

    fp_fields                  fa, fb;
    logic                      za, zb, sa, sb, a_big;
    logic [SIG_W-1:0]          sig_a, sig_b;
    logic signed [XEXP_W-1:0]  ea, eb, dmag;
    logic [WORK_W-1:0]         sum;

    fp_unpack u_unpack_a (.word(a_q), .fields(fa), .is_zero(za), .is_special(sa), .sig(sig_a));
    fp_unpack u_unpack_b (.word(b_q), .fields(fb), .is_zero(zb), .is_special(sb), .sig(sig_b));

    // Truncation toward zero: the two guard bits are simply dropped.
    function automatic logic [31:0] pack_rtz(input logic sign,
                                             input logic signed [XEXP_W-1:0] exp,
                                             input logic [WORK_W-1:0] m);
        return {sign, EXP_W'(exp), MAN_W'(m >> 2)};
    endfunction

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        out_d    = out_q;
        uf_d     = uf_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        res_uf_d = res_uf_q;
        sign_d   = sign_q;
        sub_d    = sub_q;
        exp_d    = exp_q;
        diff_d   = diff_q;
        ma_d     = ma_q;
        mb_d     = mb_q;

        a_big = {fa.exp, fa.man} >= {fb.exp, fb.man};
        ea    = {{(XEXP_W-EXP_W){1'b0}}, fa.exp};
        eb    = {{(XEXP_W-EXP_W){1'b0}}, fb.exp};
        dmag  = a_big ? (ea - eb) : (eb - ea);
        sum   = sub_q ? (ma_q - mb_q) : (ma_q + mb_q);

        case (state_q)
            IDLE: begin
                // Subtraction becomes addition of the sign-flipped subtrahend.
                if (start) begin
                    a_d     = para1;
                    b_d     = {~para2[31], para2[30:0]};
                    busy_d  = 1'b1;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                state_d  = SPECIAL;
                res_uf_d = 1'b0;
                if (sa || sb) begin
                    res_d    = fp_inf(sa ? fa.sign : fb.sign);
                    res_uf_d = 1'b1;
                end else if (za && zb) begin
                    res_d = '0;
                end else if (za) begin
                    res_d = b_q;
                end else if (zb) begin
                    res_d = a_q;
                end else if (dmag > ALIGN_LIM) begin
                    res_d = a_big ? a_q : b_q;
                end else begin
                    sign_d  = a_big ? fa.sign : fb.sign;
                    exp_d   = a_big ? ea : eb;
                    ma_d    = {1'b0, (a_big ? sig_a : sig_b), 2'b00};
                    mb_d    = {1'b0, (a_big ? sig_b : sig_a), 2'b00};
                    sub_d   = fa.sign ^ fb.sign;
                    diff_d  = EXP_W'(dmag);
                    state_d = (dmag == '0) ? ADDSUB : ALIGN;
                end
            end
            SPECIAL: begin
                out_d   = res_q;
                uf_d    = res_uf_q;
                done_d  = 1'b1;
                state_d = DONE;
            end
            ALIGN: begin
                mb_d   = mb_q >> 1;
                diff_d = diff_q - DIFF_ONE;
                if (diff_q == DIFF_ONE) begin
                    state_d = ADDSUB;
                end
            end
            ADDSUB: begin
                if (sum == '0) begin
                    out_d   = '0;
                    uf_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    ma_d    = sum;
                    state_d = NORM;
                end
            end
            NORM: begin
                // Carry needs one right step; cancellation needs left steps until bit 25.
                if (ma_q[WORK_W-1]) begin
                    ma_d  = ma_q >> 1;
                    exp_d = exp_q + EXP_ONE;
                    if (exp_q + EXP_ONE >= EXP_MAX) begin
                        out_d   = fp_inf(sign_q);
                        uf_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = PACK;
                    end
                end else if (ma_q[WORK_W-2]) begin
                    state_d = PACK;
                end else begin
                    ma_d  = ma_q << 1;
                    exp_d = exp_q - EXP_ONE;
                    if (exp_q <= EXP_ONE) begin
                        out_d   = {sign_q, 31'h0};
                        uf_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            PACK: begin
                out_d   = pack_rtz(sign_q, exp_q, ma_q);
                uf_d    = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= '0;
            uf_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            res_uf_q <= 1'b0;
            sign_q   <= 1'b0;
            sub_q    <= 1'b0;
            exp_q    <= '0;
            diff_q   <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            out_q    <= out_d;
            uf_q     <= uf_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            res_uf_q <= res_uf_d;
            sign_q   <= sign_d;
            sub_q    <= sub_d;
            exp_q    <= exp_d;
            diff_q   <= diff_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign out            = out_q;
    assign under_overflow = uf_q;
endmodule

// File: tb/tb_fp_sub_seq.sv
// Bench for fp_sub_seq: directed vectors plus randomized operands checked
// against an arithmetic model of the subtract-with-guard-bits algorithm.
module tb_fp_sub_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] para1 = '0;
    logic [31:0] para2 = '0;
    logic        busy, done, uf;
    logic [31:0] out;

    int          n_pass = 0;
    int          n_total = 0;
    bit          all_done = 1'b0;
    logic [32:0] expq[$];
    logic [31:0] hold_out = '0;
    logic        hold_uf = 1'b0;

    typedef struct {
        logic [31:0] p1;
        logic [31:0] p2;
        logic [31:0] r;
        logic        f;
        int          lat;
    } vec_t;

    vec_t tbl[12] = '{
        '{32'h41A20000, 32'h414C0000, 32'h40F00000, 1'b0, 0},
        '{32'h41A20000, 32'hC14C0000, 32'h42040000, 1'b0, 0},
        '{32'h40A00000, 32'h40A00000, 32'h00000000, 1'b0, 0},
        '{32'hC14C0000, 32'h41A20000, 32'hC2040000, 1'b0, 0},
        '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 0},
        '{32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 4},
        '{32'h4C800000, 32'h3F800000, 32'h4C800000, 1'b0, 4},
        '{32'h3F800001, 32'h3F800000, 32'h34000000, 1'b0, 0},
        '{32'h00000000, 32'h3F800000, 32'hBF800000, 1'b0, 4},
        '{32'h00400000, 32'h3F800000, 32'hBF800000, 1'b0, 4},
        '{32'h3F800000, 32'hFF800000, 32'h7F800000, 1'b1, 4},
        '{32'h00800001, 32'h00800000, 32'h00000000, 1'b1, 0}
    };

    fp_sub_seq #(.MAX_ALIGN(25)) dut (
        .clk(clk), .rst(rst), .start(start), .para1(para1), .para2(para2),
        .busy(busy), .done(done), .out(out), .under_overflow(uf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Returns {under_overflow, out}: a + (-b) on integer significands with two guard bits.
    function automatic logic [32:0] model(input logic [31:0] p1, input logic [31:0] p2);
        logic [31:0] b, big, sml;
        int          ea, eb, d, e;
        longint      ma, mb, m;
        b  = p2 ^ 32'h8000_0000;
        ea = int'(p1[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) return {1'b1, (ea == 255 ? p1[31] : b[31]), 8'hFF, 23'h0};
        if (ea == 0 && eb == 0) return 33'h0;
        if (ea == 0) return {1'b0, b};
        if (eb == 0) return {1'b0, p1};
        if (p1[30:0] >= b[30:0]) begin big = p1; sml = b; end
        else begin big = b; sml = p1; end
        d = int'(big[30:23]) - int'(sml[30:23]);
        if (d > 25) return {1'b0, big};
        ma = (longint'(big[22:0]) + 64'sh80_0000) * 4;
        mb = ((longint'(sml[22:0]) + 64'sh80_0000) * 4) >> d;
        m  = (big[31] == sml[31]) ? ma + mb : ma - mb;
        if (m == 0) return 33'h0;
        e = int'(big[30:23]);
        while (m >= (64'sd1 << 26)) begin m = m / 2; e++; end
        while (m < (64'sd1 << 25)) begin m = m * 2; e--; end
        if (e >= 255) return {1'b1, big[31], 8'hFF, 23'h0};
        if (e <= 0) return {1'b1, big[31], 31'h0};
        return {1'b0, big[31], 8'(e), m[24:2]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0: w[30:23] = 8'h00;
            1: w[30:23] = 8'hFF;
            2: w[30:23] = 8'($urandom_range(1, 6));
            3: w[30:23] = 8'($urandom_range(248, 254));
            default: w[30:23] = 8'($urandom_range(100, 160));
        endcase
        return w;
    endfunction

    function automatic logic [31:0] rnd_partner(input logic [31:0] p1);
        int          e;
        logic [22:0] man;
        if ($urandom_range(0, 2) == 0) return rnd_op();
        e = int'(p1[30:23]) + int'($urandom_range(0, 64)) - 32;
        if (e < 0) e = 0;
        if (e > 255) e = 255;
        man = ($urandom_range(0, 1) == 1) ? (p1[22:0] ^ (23'($urandom) & 23'h0000FF)) : 23'($urandom);
        return {1'($urandom), 8'(e), man};
    endfunction

    task automatic do_op(input logic [31:0] p1, input logic [31:0] p2, input bit poke, output int lat);
        @(posedge clk); #1;
        chk("idle_busy", {63'h0, busy}, 64'h0);
        expq.push_back(model(p1, p2));
        para1 = p1;
        para2 = p2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2;
        while (!done && lat < 80) begin
            chk("busy_high", {63'h0, busy}, 64'h1);
            if (poke && lat == 3) begin
                para1 = $urandom;
                para2 = $urandom;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk("done_seen", {63'h0, done}, 64'h1);
        chk("busy_at_done", {63'h0, busy}, 64'h1);
        chk("latency_max", {63'h0, (lat <= 54)}, 64'h1);
    endtask

    initial begin
        fork
            begin
                int          lat;
                int          extra;
                logic [31:0] p1;
                repeat (2) @(posedge clk);
                #1;
                chk("reset_busy", {63'h0, busy}, 64'h0);
                chk("reset_done", {63'h0, done}, 64'h0);
                chk("reset_out", {32'h0, out}, 64'h0);
                chk("reset_uf", {63'h0, uf}, 64'h0);
                rst = 1'b0;

                for (int i = 0; i < 12; i++) begin
                    chk("model_pin", {31'h0, model(tbl[i].p1, tbl[i].p2)}, {31'h0, tbl[i].f, tbl[i].r});
                    do_op(tbl[i].p1, tbl[i].p2, 1'b0, lat);
                    if (tbl[i].lat != 0) chk("latency_min", 64'(lat), 64'(tbl[i].lat));
                end

                do_op(32'h4C000000, 32'h3F800000, 1'b1, lat);
                extra = 0;
                repeat (60) begin
                    @(posedge clk); #1;
                    if (done) extra++;
                end
                chk("single_done", 64'(extra), 64'h0);

                @(posedge clk); #1;
                expq.push_back(model(32'h4C000000, 32'h3F800000));
                para1 = 32'h4C000000;
                para2 = 32'h3F800000;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                rst = 1'b1;
                #1;
                chk("abort_busy", {63'h0, busy}, 64'h0);
                chk("abort_done", {63'h0, done}, 64'h0);
                chk("abort_out", {32'h0, out}, 64'h0);
                chk("abort_uf", {63'h0, uf}, 64'h0);
                @(negedge clk);
                @(posedge clk); #1;
                rst = 1'b0;
                do_op(32'h41A20000, 32'h414C0000, 1'b0, lat);

                for (int i = 0; i < 250; i++) begin
                    p1 = rnd_op();
                    do_op(p1, rnd_partner(p1), 1'b0, lat);
                end
                repeat (3) @(posedge clk);
                all_done = 1'b1;
            end
            begin
                logic [32:0] e;
                while (!all_done) begin
                    @(negedge clk);
                    if (rst) begin
                        expq.delete();
                        hold_out = '0;
                        hold_uf  = 1'b0;
                    end else if (done) begin
                        if (expq.size() == 0) begin
                            chk("done_without_request", 64'(expq.size()), 64'h1);
                        end else begin
                            e = expq.pop_front();
                            chk("result", {31'h0, uf, out}, {31'h0, e});
                            hold_uf  = e[32];
                            hold_out = e[31:0];
                        end
                    end else begin
                        chk("hold", {31'h0, uf, out}, {31'h0, hold_uf, hold_out});
                    end
                end
            end
        join
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
